// File: rtl/i2c_reg_pkg.sv
// rtl/i2c_reg_pkg.sv - I2C master core register map, command bits and arbiter state encoding
//
// Shared by everything that talks to the I2C master core register port:
//   register addresses, CMD register bit values, STATUS bit positions,
//   upload source IDs and the arbiter FSM state type.
package i2c_reg_pkg;

    // Core register addresses (3-bit register port)
    localparam logic [2:0] ADDR_PRESCALE_LO = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE_HI = 3'd1;
    localparam logic [2:0] ADDR_CTRL        = 3'd2;
    localparam logic [2:0] ADDR_TX          = 3'd3;
    localparam logic [2:0] ADDR_RX          = 3'd3;
    localparam logic [2:0] ADDR_CMD         = 3'd4;
    localparam logic [2:0] ADDR_STATUS      = 3'd4;

    // CMD register bits
    localparam logic [7:0] CMD_STA  = 8'h80;
    localparam logic [7:0] CMD_STO  = 8'h40;
    localparam logic [7:0] CMD_RD   = 8'h20;
    localparam logic [7:0] CMD_WR   = 8'h10;
    localparam logic [7:0] CMD_ACK  = 8'h08;
    localparam logic [7:0] CMD_IACK = 8'h01;

    // STATUS register bit index: transfer in progress
    localparam int STATUS_TIP = 1;

    // Upload source IDs (requester index on the arbiter)
    localparam int SRC_CDC  = 0;
    localparam int SRC_POLL = 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_ABORT_STO  = 2'd2,
        ST_ABORT_POLL = 2'd3
    } arb_state_e;

endpackage

// File: rtl/i2c_sram_arbiter_if.sv
// rtl/i2c_sram_arbiter_if.sv - requester and core-side bus bundle of the I2C register port arbiter
//
// Requester side: req, gnt, abort, r_tx_en/r_waddr/r_wdata, r_rx_en/r_raddr, r_rdata, busy.
// Core side:      I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR, O_RDATA.
// slave  = arbiter view; master = environment (requesters + core) view.
interface i2c_sram_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   abort;
    logic [NREQ-1:0]   r_tx_en;
    logic [3*NREQ-1:0] r_waddr;
    logic [8*NREQ-1:0] r_wdata;
    logic [NREQ-1:0]   r_rx_en;
    logic [3*NREQ-1:0] r_raddr;
    logic [7:0]        r_rdata;
    logic              busy;

    logic              I_TX_EN;
    logic [2:0]        I_WADDR;
    logic [7:0]        I_WDATA;
    logic              I_RX_EN;
    logic [2:0]        I_RADDR;
    logic [7:0]        O_RDATA;

    modport slave (
        input  req, r_tx_en, r_waddr, r_wdata, r_rx_en, r_raddr, O_RDATA,
        output gnt, abort, busy, r_rdata,
               I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR
    );

    modport master (
        output req, r_tx_en, r_waddr, r_wdata, r_rx_en, r_raddr, O_RDATA,
        input  gnt, abort, busy, r_rdata,
               I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick
//
// Ports:
//   req   in  N             request vector
//   ptr   in  $clog2(N)     index searched first; search wraps upward mod N
//   gnt   out N             one-hot winner (all zero when no request)
//   valid out 1             any request present
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 valid
);
    localparam int PW = $clog2(N);

    // ptr + off wrapped into 0..N-1 (N need not be a power of two)
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = wrap_add(ptr, k);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_sram_arbiter.sv
// rtl/i2c_sram_arbiter.sv - round-robin arbiter sharing the I2C master core register port
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of i2c_sram_arbiter_if:
//          req/gnt/abort per requester, per-requester register strobes,
//          broadcast r_rdata, busy, and the core register port I_* / O_RDATA.
// A grant lasts until the grantee drops req. A grantee silent for TIMEOUT_CYC
// cycles is revoked; the arbiter then writes STO to CMD and polls STATUS until
// TIP clears. An aborted requester stays masked until it drops req.
module i2c_sram_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    i2c_sram_arbiter_if.slave bus
);
    import i2c_reg_pkg::*;

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] abort_q, abort_d;
    logic [NREQ-1:0] mask_q, mask_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick;
    logic            pick_valid;
    logic            grantee_req;
    logic            grantee_strobe;
    logic            timeout;

    assign eligible       = bus.req & ~mask_q;
    assign grantee_req    = |(bus.req & gnt_q);
    assign grantee_strobe = |((bus.r_tx_en | bus.r_rx_en) & gnt_q);
    assign timeout        = (cnt_q == CW'(TIMEOUT_CYC));

    rr_arbiter #(.N(NREQ)) u_rr (
        .req   (eligible),
        .ptr   (ptr_q),
        .gnt   (pick),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            abort_q <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            abort_q <= abort_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        abort_d = '0;
        ptr_d   = ptr_q;
        cnt_d   = '0;
        // A mask bit survives only while its requester keeps req high.
        mask_d  = mask_q & bus.req;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick[i]) ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
                    end
                end
            end
            ST_GRANT: begin
                // Release is checked first so a release coinciding with the
                // timeout ends the grant cleanly without a STOP.
                if (!grantee_req) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (timeout) begin
                    state_d = ST_ABORT_STO;
                    gnt_d   = '0;
                    abort_d = gnt_q;
                    mask_d  = mask_d | gnt_q;
                end else if (!grantee_strobe) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ABORT_STO: begin
                gnt_d   = '0;
                state_d = ST_ABORT_POLL;
            end
            ST_ABORT_POLL: begin
                gnt_d = '0;
                if (!bus.O_RDATA[STATUS_TIP]) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Core register port: grantee passes straight through; abort sequence
    // owns the port otherwise; idle drives zeros.
    always_comb begin
        bus.I_TX_EN = 1'b0;
        bus.I_WADDR = '0;
        bus.I_WDATA = '0;
        bus.I_RX_EN = 1'b0;
        bus.I_RADDR = '0;
        case (state_q)
            ST_GRANT: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt_q[i]) begin
                        bus.I_TX_EN = bus.r_tx_en[i];
                        bus.I_WADDR = bus.r_waddr[3*i +: 3];
                        bus.I_WDATA = bus.r_wdata[8*i +: 8];
                        bus.I_RX_EN = bus.r_rx_en[i];
                        bus.I_RADDR = bus.r_raddr[3*i +: 3];
                    end
                end
            end
            ST_ABORT_STO: begin
                bus.I_TX_EN = 1'b1;
                bus.I_WADDR = ADDR_CMD;
                bus.I_WDATA = CMD_STO;
            end
            ST_ABORT_POLL: begin
                bus.I_RX_EN = 1'b1;
                bus.I_RADDR = ADDR_STATUS;
            end
            default: begin
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.abort   = abort_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.r_rdata = bus.O_RDATA;

endmodule

// File: tb/tb_i2c_sram_arbiter.sv
// tb/tb_i2c_sram_arbiter.sv - self-checking bench for i2c_sram_arbiter
module tb_i2c_sram_arbiter;
    import i2c_reg_pkg::*;

    localparam int NREQ = 2;
    localparam int TO   = 16;
    localparam logic [5:0] RD_HI = 6'h2A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_sram_arbiter_if #(.NREQ(NREQ)) bus ();

    i2c_sram_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Core model: TIP stays high for tip_left STATUS polls.
    int tip_left = 0;
    assign bus.O_RDATA = {RD_HI, tip_left != 0, 1'b0};
    always @(posedge clk) if (bus.I_RX_EN && tip_left > 0) tip_left <= tip_left - 1;

    logic [1:0]  exp_gnt_q[$];
    logic [10:0] exp_wr_q[$];
    logic [1:0]  exp_abort_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag);
        int k;
        k = 0;
        while (bus.gnt == '0 && k < 20) begin
            tick();
            k++;
        end
        check(tag, {31'b0, bus.gnt != '0}, 32'd1);
    endtask

    // Scoreboard monitors
    logic [1:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (bus.gnt != '0 && bus.gnt != prev_gnt) begin
            if (exp_gnt_q.size() == 0) check("gnt_unexpected", {30'b0, bus.gnt}, 32'd0);
            else check("gnt_order", {30'b0, bus.gnt}, {30'b0, exp_gnt_q.pop_front()});
        end
        prev_gnt = bus.gnt;
        if (bus.I_TX_EN) begin
            if (exp_wr_q.size() == 0) check("core_wr_unexpected", {31'b0, bus.I_TX_EN}, 32'd0);
            else check("core_wr", {21'b0, bus.I_WADDR, bus.I_WDATA}, {21'b0, exp_wr_q.pop_front()});
        end
        if (bus.abort != '0) begin
            if (exp_abort_q.size() == 0) check("abort_unexpected", {30'b0, bus.abort}, 32'd0);
            else check("abort_pulse", {30'b0, bus.abort}, {30'b0, exp_abort_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    logic [1:0] g;
    int gi, lat, rx;

    initial begin
        bus.req = '0; bus.r_tx_en = '0; bus.r_rx_en = '0;
        bus.r_waddr = '0; bus.r_wdata = '0; bus.r_raddr = '0;
        rst_n = 1'b0;
        tick(); tick();
        check("rst_gnt", {30'b0, bus.gnt}, 32'd0);
        check("rst_abort", {30'b0, bus.abort}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_core", {bus.I_TX_EN, bus.I_WADDR, bus.I_WDATA, bus.I_RX_EN, bus.I_RADDR}, 32'd0);
        check("rst_rdata", {24'b0, bus.r_rdata}, 32'hA8);
        rst_n = 1'b1;
        tick();

        // Single requester 0: grant 1 cycle after req, write passes same cycle
        bus.req = 2'b01;
        exp_gnt_q.push_back(2'b01);
        tick();
        check("t1_gnt", {30'b0, bus.gnt}, 32'd1);
        check("t1_busy", {31'b0, bus.busy}, 32'd1);
        bus.r_tx_en = 2'b01; bus.r_waddr[2:0] = ADDR_CMD; bus.r_wdata[7:0] = CMD_STA | CMD_WR;
        exp_wr_q.push_back({ADDR_CMD, 8'h90});
        #2 check("t1_core_wr", {20'b0, bus.I_TX_EN, bus.I_WADDR, bus.I_WDATA}, {20'b0, 1'b1, 3'd4, 8'h90});
        tick(); bus.r_tx_en = '0;
        tick(); tick();
        tick(); bus.req = '0;
        tick();
        check("t1_release_gnt", {30'b0, bus.gnt}, 32'd0);
        check("t1_release_busy", {31'b0, bus.busy}, 32'd0);

        // Round robin from reset, req=11: 0,1,0,1 with one idle bubble each
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        bus.req = 2'b11;
        exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10);
        exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10);
        for (int k = 0; k < 4; k++) begin
            wait_gnt("t2_wait_gnt");
            g  = bus.gnt;
            gi = g[1] ? 1 : 0;
            if (k == 0) begin
                bus.r_tx_en = 2'b10; bus.r_waddr[5:3] = ADDR_TX; bus.r_wdata[15:8] = 8'hAA;
                #2 check("t3_foreign_tx", {31'b0, bus.I_TX_EN}, 32'd0);
                tick(); bus.r_tx_en = '0;
            end
            bus.r_tx_en[gi] = 1'b1;
            bus.r_waddr[3*gi +: 3] = ADDR_TX;
            bus.r_wdata[8*gi +: 8] = 8'(8'h10 + k);
            exp_wr_q.push_back({ADDR_TX, 8'(8'h10 + k)});
            tick(); bus.r_tx_en = '0;
            bus.req = (k == 3) ? 2'b00 : (bus.req & ~g);
            tick();
            check("t2_idle_bubble", {30'b0, bus.gnt}, 32'd0);
            if (k < 3) bus.req = 2'b11;
            tick();
        end
        tick();

        // Watchdog: requester 0 silent, requester 1 waiting
        tip_left = 5;
        bus.req = 2'b01;
        exp_gnt_q.push_back(2'b01);
        wait_gnt("t4_wait_gnt0");
        bus.req = 2'b11;
        exp_gnt_q.push_back(2'b10);
        exp_abort_q.push_back(2'b01);
        exp_wr_q.push_back({ADDR_CMD, CMD_STO});
        lat = 0;
        while (bus.abort == '0 && lat < 40) begin tick(); lat++; end
        check("t4_abort_latency", lat, TO + 1);
        check("t4_stop_write", {20'b0, bus.I_TX_EN, bus.I_WADDR, bus.I_WDATA}, {20'b0, 1'b1, ADDR_CMD, CMD_STO});
        check("t4_gnt_revoked", {30'b0, bus.gnt}, 32'd0);
        tick();
        check("t4_rdata_tip", {24'b0, bus.r_rdata}, 32'hAA);
        rx = 0; lat = 0;
        while (bus.busy && lat < 40) begin
            if (bus.I_RX_EN && bus.I_RADDR == ADDR_STATUS) rx++;
            tick(); lat++;
        end
        check("t4_poll_cycles", rx, 6);
        check("t4_idle_after_poll", {31'b0, bus.busy}, 32'd0);
        wait_gnt("t4_wait_gnt1");
        check("t4_gnt1", {30'b0, bus.gnt}, 32'd2);
        bus.r_tx_en = 2'b10; bus.r_waddr[5:3] = ADDR_TX; bus.r_wdata[15:8] = 8'h5C;
        exp_wr_q.push_back({ADDR_TX, 8'h5C});
        tick(); bus.r_tx_en = '0; bus.req = 2'b01;
        tick(); tick(); tick();
        check("t4_masked_gnt", {30'b0, bus.gnt}, 32'd0);
        check("t4_masked_busy", {31'b0, bus.busy}, 32'd0);
        bus.req = 2'b00; tick();
        bus.req = 2'b01;
        exp_gnt_q.push_back(2'b01);
        wait_gnt("t4_wait_regrant");
        check("t4_regrant0", {30'b0, bus.gnt}, 32'd1);

        // Release in the same cycle the timeout fires: release wins
        repeat (TO) tick();
        bus.req = 2'b00;
        tick();
        check("t5_abort", {30'b0, bus.abort}, 32'd0);
        check("t5_gnt", {30'b0, bus.gnt}, 32'd0);
        check("t5_no_stop", {31'b0, bus.I_TX_EN}, 32'd0);
        tick();
        check("t5_idle", {31'b0, bus.busy}, 32'd0);
        check("t5_no_stop2", {31'b0, bus.I_TX_EN}, 32'd0);

        // Reset during ABORT_POLL
        tip_left = 100;
        bus.req = 2'b01;
        exp_gnt_q.push_back(2'b01);
        wait_gnt("t6_wait_gnt");
        exp_abort_q.push_back(2'b01);
        exp_wr_q.push_back({ADDR_CMD, CMD_STO});
        repeat (TO + 1) tick();
        tick(); tick();
        check("t6_in_poll", {31'b0, bus.I_RX_EN}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", {30'b0, bus.gnt}, 32'd0);
        check("t6_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("t6_rst_core", {bus.I_TX_EN, bus.I_WADDR, bus.I_WDATA, bus.I_RX_EN, bus.I_RADDR}, 32'd0);
        check("t6_rst_abort", {30'b0, bus.abort}, 32'd0);
        tip_left = 0;
        tick();
        rst_n = 1'b1;
        bus.req = 2'b11;
        exp_gnt_q.push_back(2'b01);
        wait_gnt("t6_wait_after_rst");
        check("t6_first_winner", {30'b0, bus.gnt}, 32'd1);
        bus.req = 2'b00;
        tick(); tick(); tick();

        check("sb_gnt_drained", exp_gnt_q.size(), 0);
        check("sb_wr_drained", exp_wr_q.size(), 0);
        check("sb_abort_drained", exp_abort_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_sram_arbiter.md
# i2c_sram_arbiter

Shares the single I2C master core's register interface (3-bit address, 8-bit write/read strobes, combinational read-back) between up to four command sources: the CDC I2C command handler, the sensor poller, and future clients. Round-robin grants last one full I2C transaction. A watchdog revokes a stalled grant, then issues STOP to the core and waits for TIP to clear before re-arbitrating. Sits between the requesters and the I2C master core.

## Interface
- NREQ, 2, number of requesters (2..4); requester 0 is the CDC handler
- TIMEOUT_CYC, 1000000, idle cycles (no strobe from grantee) before abort; 20 ms at 50 MHz
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester transaction request; level, held for the whole transaction
- gnt  out  NREQ  one-hot grant, registered
- r_tx_en  in  NREQ  per-requester register write strobe
- r_waddr  in  3*NREQ  write address, requester i at [3i+2:3i]
- r_wdata  in  8*NREQ  write data, requester i at [8i+7:8i]
- r_rx_en  in  NREQ  per-requester register read strobe
- r_raddr  in  3*NREQ  read address, requester i at [3i+2:3i]
- r_rdata  out  8  core O_RDATA broadcast to all requesters
- abort  out  NREQ  one-cycle pulse on the bit of the requester whose grant was revoked
- busy  out  1  high whenever state is not IDLE
- I_TX_EN, I_WADDR[2:0], I_WDATA[7:0], I_RX_EN, I_RADDR[2:0]  out  core register port
- O_RDATA  in  8  core read data, combinational on I_RADDR

## Operation
- States: IDLE, GRANT, ABORT_STO, ABORT_POLL.
- IDLE:
  - Eligible = req & ~abort_mask.
  - If any requester is eligible, pick the first set bit searching from rr_ptr upward (mod NREQ).
  - Next cycle: gnt is one-hot, state is GRANT, rr_ptr = winner+1 mod NREQ.
- GRANT:
  - Core port = granted requester's strobes, address and data. Combinational mux, no added latency.
  - Strobes from non-granted requesters are ignored (not queued).
  - Grantee deasserts req: next cycle gnt=0, state IDLE.
  - Watchdog counter clears on grant and on any grantee tx_en/rx_en. It increments otherwise.
  - Counter reaches TIMEOUT_CYC: gnt=0, abort pulse, set abort_mask[i], go to ABORT_STO.
- ABORT_STO (one cycle): I_TX_EN=1, I_WADDR=4 (CMD), I_WDATA=8'h40 (STO).
- ABORT_POLL: I_RX_EN=1, I_RADDR=4 (STATUS). When O_RDATA[1] (TIP) is 0, go to IDLE.
- abort_mask[i] clears when req[i] is low. An aborted requester must drop req before it can be granted again.
- In IDLE, ABORT_STO and ABORT_POLL, no requester reaches the core port. All core outputs are 0 except the abort accesses.
- Counter width $clog2(TIMEOUT_CYC+1); it saturates and never wraps.

## Timing
- Reset values:
  - gnt=0, abort=0, busy=0, state IDLE, rr_ptr=0, abort_mask=0, counter=0.
  - All I_* outputs are 0.
- Reset asserted mid-transaction: everything returns to reset values immediately. No STOP is issued.
- Latency:
  - req to gnt: 1 cycle when the arbiter is idle.
  - Release to next grant: 2 cycles minimum (one IDLE bubble).
  - Timeout to STOP write: 1 cycle.
- Requester strobes asserted in the same cycle gnt rises are honoured. Requesters should wait for gnt.
- Grantee releases req in the same cycle the timeout fires: release wins. No abort, no STOP.
- A req pulse that drops before its grant cycle still yields a one-cycle grant, then release.
- r_rdata = O_RDATA in all states.

## Structure
- Shared package i2c_reg_pkg holds:
  - register addresses (PRESCALE_LO=0, PRESCALE_HI=1, CTRL=2, TX/RX=3, CMD/STATUS=4);
  - CMD bits (STA 80, STO 40, RD 20, WR 10, ACK 08, IACK 01);
  - STATUS_TIP=1; upload source IDs.
- Sub-module rr_arbiter: combinational round-robin pick (req, ptr -> one-hot, valid), reusable for the upload mux.
- The FSM, watchdog and port mux live in the top module.

## Test plan
- Single requester 0: req at t0 -> gnt[0] at t1. Writes CMD=0x90 appear on I_* the same cycle. Release at t5 -> gnt=0 at t6.
- req=2'b11 from reset -> grant order 0,1,0,1 across four back-to-back transactions. Each release is followed by one idle cycle.
- Requester 1 strobes I_TX_EN while 0 holds gnt -> I_TX_EN stays 0 on the core port.
- TIMEOUT_CYC=16, grantee silent -> at cycle 16: abort[0] pulse, then write CMD 0x40. Poll STATUS with model TIP high 5 cycles -> IDLE; requester 1 is granted next; requester 0 is not re-granted until it drops req.
- Release and timeout in the same cycle -> no abort pulse, no STOP write.
- rst_n asserted during ABORT_POLL -> all outputs 0 immediately; after reset, requester 0 wins first.
